// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - multicycle instruction fetch stage with redirect, alignment and timeout handling
module busca_instrucao #(
   parameter logic [31:0] PC_INICIAL  = 32'h0000_0000,
   parameter int          MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        habilita,
   input  logic        consumir,
   input  logic        desvio_valido,
   input  logic [31:0] desvio_alvo,
   output logic [31:0] mem_endereco,
   output logic        mem_leitura,
   input  logic        mem_pronto,
   input  logic [31:0] mem_dado,
   output logic [31:0] pc,
   output logic [31:0] pc_mais4,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imediato,
   output logic        instr_valida,
   output logic        ocupado,
   output logic        erro_timeout,
   output logic        erro_alinhamento
);

   typedef enum logic [1:0] {OCIOSO, BUSCA, VALIDA} estado_t;

   localparam logic [7:0] LIMITE = 8'(MEM_TIMEOUT);

   estado_t     estado_q, estado_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [7:0]  cont_q, cont_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_alvo_q, pend_alvo_d;
   logic        erro_to_q, erro_to_d;
   logic        erro_al_q, erro_al_d;

   logic        alvo_ok;
   logic        redir;
   logic [31:0] alvo;
   logic [7:0]  cont_inc;

   assign alvo_ok = (desvio_alvo[1:0] == 2'b00);

   always_comb begin
      estado_d    = estado_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      cont_d      = cont_q;
      pend_d      = pend_q;
      pend_alvo_d = pend_alvo_q;
      erro_to_d   = erro_to_q;
      erro_al_d   = erro_al_q;
      redir       = 1'b0;
      alvo        = pend_alvo_q;
      cont_inc    = cont_q + 8'd1;

      case (estado_q)
         OCIOSO: begin
            if (desvio_valido) begin
               if (alvo_ok) pc_d = desvio_alvo;
               else         erro_al_d = 1'b1;
            end else if (habilita) begin
               estado_d    = BUSCA;
               cont_d      = 8'd0;
               pend_d      = 1'b0;
               pend_alvo_d = pc_q;
            end
         end
         BUSCA: begin
            cont_d = cont_inc;
            // A misaligned target still forces the read to be discarded, but
            // leaves the pending target (initialised to pc) untouched.
            if (desvio_valido) begin
               pend_d = 1'b1;
               if (alvo_ok) begin
                  pend_alvo_d = desvio_alvo;
                  alvo        = desvio_alvo;
               end else begin
                  erro_al_d = 1'b1;
               end
            end
            redir = pend_q | desvio_valido;
            if (mem_pronto) begin
               if (redir) begin
                  pc_d     = alvo;
                  estado_d = OCIOSO;
               end else begin
                  instr_d  = mem_dado;
                  pc_d     = pc_q + 32'd4;
                  estado_d = VALIDA;
               end
            end else if (cont_inc == LIMITE) begin
               erro_to_d = 1'b1;
               estado_d  = OCIOSO;
               if (redir) pc_d = alvo;
            end
         end
         VALIDA: begin
            if (desvio_valido) begin
               estado_d = OCIOSO;
               if (alvo_ok) pc_d = desvio_alvo;
               else         erro_al_d = 1'b1;
            end else if (consumir) begin
               estado_d    = habilita ? BUSCA : OCIOSO;
               cont_d      = 8'd0;
               pend_d      = 1'b0;
               pend_alvo_d = pc_q;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q    <= OCIOSO;
         pc_q        <= PC_INICIAL;
         instr_q     <= 32'd0;
         cont_q      <= 8'd0;
         pend_q      <= 1'b0;
         pend_alvo_q <= PC_INICIAL;
         erro_to_q   <= 1'b0;
         erro_al_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         cont_q      <= cont_d;
         pend_q      <= pend_d;
         pend_alvo_q <= pend_alvo_d;
         erro_to_q   <= erro_to_d;
         erro_al_q   <= erro_al_d;
      end
   end

   assign pc               = pc_q;
   assign pc_mais4         = pc_q + 32'd4;
   assign mem_endereco     = pc_q;
   assign mem_leitura      = (estado_q == BUSCA);
   assign ocupado          = (estado_q == BUSCA);
   assign instr_valida     = (estado_q == VALIDA);
   assign instr            = instr_q;
   assign opcode           = instr_q[31:26];
   assign rs               = instr_q[25:21];
   assign rt               = instr_q[20:16];
   assign rd               = instr_q[15:11];
   assign shamt            = instr_q[10:6];
   assign funct            = instr_q[5:0];
   assign imediato         = instr_q[15:0];
   assign erro_timeout     = erro_to_q;
   assign erro_alinhamento = erro_al_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - self-checking bench for busca_instrucao
module tb_busca_instrucao;

   localparam logic [31:0] PC0 = 32'h0000_0100;
   localparam int          TMO = 8;

   logic        clk = 1'b0;
   logic        reset, habilita, consumir, desvio_valido;
   logic [31:0] desvio_alvo;
   logic [31:0] mem_endereco;
   logic        mem_leitura, mem_pronto;
   logic [31:0] mem_dado;
   logic [31:0] pc, pc_mais4, instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imediato;
   logic        instr_valida, ocupado, erro_timeout, erro_alinhamento;

   int          errors = 0;
   int          checks = 0;

   // memory responder: answers in the resp_lat-th read cycle (0 = never)
   int          resp_lat = 0;
   int          busca_cnt = 0;
   logic        forca_pronto = 1'b0;

   // reference model state
   logic [31:0] m_pc, m_instr;
   logic        m_valid, m_to, m_al;

   busca_instrucao #(.PC_INICIAL(PC0), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .habilita(habilita), .consumir(consumir),
      .desvio_valido(desvio_valido), .desvio_alvo(desvio_alvo),
      .mem_endereco(mem_endereco), .mem_leitura(mem_leitura),
      .mem_pronto(mem_pronto), .mem_dado(mem_dado),
      .pc(pc), .pc_mais4(pc_mais4), .instr(instr),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imediato(imediato), .instr_valida(instr_valida), .ocupado(ocupado),
      .erro_timeout(erro_timeout), .erro_alinhamento(erro_alinhamento)
   );

   always #5 clk = ~clk;

   always @(posedge clk) busca_cnt <= mem_leitura ? busca_cnt + 1 : 0;

   assign mem_pronto = forca_pronto |
                       (mem_leitura && resp_lat != 0 && busca_cnt + 1 == resp_lat);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string nome);
      checks++;
      if (pc !== m_pc) begin
         errors++; $display("FAIL %s pc got=%h exp=%h", nome, pc, m_pc);
      end
      checks++;
      if (instr !== m_instr) begin
         errors++; $display("FAIL %s instr got=%h exp=%h", nome, instr, m_instr);
      end
      checks++;
      if (instr_valida !== m_valid) begin
         errors++; $display("FAIL %s instr_valida got=%b exp=%b", nome, instr_valida, m_valid);
      end
      checks++;
      if ({erro_timeout, erro_alinhamento} !== {m_to, m_al}) begin
         errors++; $display("FAIL %s flags got=%b%b exp=%b%b", nome, erro_timeout,
                            erro_alinhamento, m_to, m_al);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_pc = PC0; m_instr = 32'd0; m_valid = 1'b0; m_to = 1'b0; m_al = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      check_model("reset");
      checks++;
      if ({mem_leitura, ocupado} !== 2'b00 || mem_endereco !== PC0) begin
         errors++; $display("FAIL reset_bus got=%b%b/%h exp=00/%h", mem_leitura, ocupado,
                            mem_endereco, PC0);
      end
   endtask

   task automatic test_fetch_basic();
      int n;
      resp_lat = 3;
      mem_dado = 32'h2008FFFC;
      habilita = 1'b1;
      tick();
      habilita = 1'b0;
      n = 1;
      checks++;
      if (mem_leitura !== 1'b1 || ocupado !== 1'b1 || mem_endereco !== PC0) begin
         errors++; $display("FAIL fetch_busca got=%b%b/%h exp=11/%h", mem_leitura, ocupado,
                            mem_endereco, PC0);
      end
      while (!instr_valida && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 4) begin
         errors++; $display("FAIL fetch_latency got=%0d exp=4", n);
      end
      m_pc = PC0 + 4; m_instr = 32'h2008FFFC; m_valid = 1'b1;
      check_model("fetch_basic");
      checks++;
      if (opcode !== 6'h08 || rt !== 5'd8 || rs !== 5'd0 || imediato !== 16'hFFFC ||
          pc_mais4 !== PC0 + 8) begin
         errors++; $display("FAIL fetch_fields got=%h/%h/%h/%h/%h exp=08/08/00/fffc/%h",
                            opcode, rt, rs, imediato, pc_mais4, PC0 + 8);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      d = $urandom;
      resp_lat = 1;
      mem_dado = d;
      consumir = 1'b1; habilita = 1'b1;
      tick();
      consumir = 1'b0; habilita = 1'b0;
      checks++;
      if (instr_valida !== 1'b0 || mem_leitura !== 1'b1 || mem_endereco !== m_pc ||
          instr !== m_instr) begin
         errors++; $display("FAIL b2b_busca got=%b%b/%h exp=01/%h", instr_valida, mem_leitura,
                            mem_endereco, m_pc);
      end
      tick();
      m_pc = m_pc + 4; m_instr = d; m_valid = 1'b1;
      check_model("b2b_zero_latency");
   endtask

   task automatic test_redirect_busca();
      resp_lat = 3;
      mem_dado = 32'hDEAD_BEEF;
      consumir = 1'b1; habilita = 1'b1;
      tick();
      consumir = 1'b0; habilita = 1'b0;
      desvio_valido = 1'b1; desvio_alvo = 32'h0000_0040;
      tick();
      desvio_valido = 1'b0;
      tick();
      tick();
      m_pc = 32'h40; m_valid = 1'b0;
      check_model("redirect_busca");
      checks++;
      if (ocupado !== 1'b0 || mem_leitura !== 1'b0) begin
         errors++; $display("FAIL redirect_idle got=%b%b exp=00", ocupado, mem_leitura);
      end
   endtask

   task automatic test_timeout();
      int n;
      resp_lat = 0;
      habilita = 1'b1;
      tick();
      habilita = 1'b0;
      n = 0;
      while (mem_leitura && n < 100) begin
         n++;
         tick();
      end
      checks++;
      if (n !== TMO) begin
         errors++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TMO);
      end
      m_to = 1'b1;
      check_model("timeout");
      // fetching continues with the flag set
      resp_lat = 2;
      mem_dado = 32'h0123_4567;
      habilita = 1'b1;
      tick();
      habilita = 1'b0;
      tick();
      tick();
      m_pc = m_pc + 4; m_instr = 32'h0123_4567; m_valid = 1'b1;
      check_model("fetch_after_timeout");
      do_reset();
      check_model("timeout_cleared");
   endtask

   task automatic test_alinhamento();
      desvio_valido = 1'b1; desvio_alvo = 32'h0000_0042;
      tick();
      desvio_valido = 1'b0;
      m_al = 1'b1;
      check_model("misaligned_ocioso");
      // squash from VALIDA with an aligned target
      resp_lat = 1; mem_dado = 32'h8C22_0010;
      habilita = 1'b1;
      tick();
      habilita = 1'b0;
      tick();
      m_pc = m_pc + 4; m_instr = 32'h8C22_0010; m_valid = 1'b1;
      check_model("fetch_before_squash");
      desvio_valido = 1'b1; desvio_alvo = 32'h0000_2000; consumir = 1'b1;
      tick();
      desvio_valido = 1'b0; consumir = 1'b0;
      m_pc = 32'h2000; m_valid = 1'b0;
      check_model("squash_valida");
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      desvio_valido = 1'b1; desvio_alvo = 32'hFFFF_FFFC;
      tick();
      desvio_valido = 1'b0;
      resp_lat = 2; mem_dado = 32'h03E0_0008;
      habilita = 1'b1;
      tick();
      habilita = 1'b0;
      tick();
      tick();
      m_pc = 32'h0; m_instr = 32'h03E0_0008; m_valid = 1'b1;
      check_model("pc_wrap");
      resp_lat = 0;
      consumir = 1'b1; habilita = 1'b1;
      tick();
      consumir = 1'b0; habilita = 1'b0;
      tick();
      do_reset();
      forca_pronto = 1'b1; mem_dado = 32'hFFFF_FFFF;
      tick();
      forca_pronto = 1'b0;
      check_model("reset_mid_busca");
      checks++;
      if (mem_leitura !== 1'b0) begin
         errors++; $display("FAIL late_pronto mem_leitura got=%b exp=0", mem_leitura);
      end
   endtask

   task automatic test_random();
      int lat, k, c;
      logic redir;
      logic [31:0] d, alvo;
      for (int it = 0; it < 40; it++) begin
         if (m_valid && $urandom_range(0, 3) == 0) begin
            consumir = 1'b1;
            tick();
            consumir = 1'b0;
            m_valid = 1'b0;
            check_model("rnd_consume_only");
         end
         lat   = $urandom_range(1, TMO - 1);
         redir = ($urandom_range(0, 2) == 0);
         k     = $urandom_range(1, lat);
         d     = $urandom;
         alvo  = {$urandom} & 32'hFFFF_FFFC;
         resp_lat = lat; mem_dado = d;
         consumir = m_valid; habilita = 1'b1;
         tick();
         consumir = 1'b0; habilita = 1'b0;
         c = 0;
         while (c < 40) begin
            c++;
            desvio_valido = redir && (c == k);
            desvio_alvo   = alvo;
            tick();
            desvio_valido = 1'b0;
            if (!ocupado) break;
         end
         checks++;
         if (c !== lat) begin
            errors++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, c, lat);
         end
         if (redir) begin
            m_pc = alvo; m_valid = 1'b0;
         end else begin
            m_pc = m_pc + 4; m_instr = d; m_valid = 1'b1;
         end
         check_model("rnd_fetch");
         checks++;
         if (opcode !== 6'(m_instr >> 26) || rs !== 5'(m_instr >> 21) ||
             rt !== 5'(m_instr >> 16) || rd !== 5'(m_instr >> 11) ||
             shamt !== 5'(m_instr >> 6) || funct !== 6'(m_instr) ||
             imediato !== 16'(m_instr)) begin
            errors++; $display("FAIL rnd_fields it=%0d instr=%h", it, m_instr);
         end
      end
   endtask

   initial begin
      reset = 1'b1; habilita = 1'b0; consumir = 1'b0;
      desvio_valido = 1'b0; desvio_alvo = 32'd0; mem_dado = 32'd0;
      tick();
      test_reset();
      test_fetch_basic();
      test_back_to_back();
      test_redirect_busca();
      test_timeout();
      test_alinhamento();
      test_wrap_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
